frame_strobe_sequencer: RTL and testbench
=========================================

FRAME_STROBE_SEQUENCER -- requirements
Module: frame_strobe_sequencer

Interface
REQ-001 SHALL have parameter MaxFramesPerCol, default 36, number of one-hot frame strobes per column.
REQ-002 SHALL have parameter FrameBitsPerRow, default 32, frame data word width.
REQ-003 SHALL have parameter SetupCycles, default 1 (range 1-7), cycles FrameData is stable before strobe.
REQ-004 SHALL have parameter StrobeCycles, default 2 (range 1-7), strobe pulse width in cycles.
REQ-005 SHALL use one clock and a synchronous, active-high reset: UserCLK  input  1  sole clock, all state on rising edge.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 cfg_start  input  1  single-cycle request to open a configuration session.
REQ-008 cmd_valid  input  1  frame-write command valid.
REQ-009 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready at a rising edge.
REQ-010 cmd_frame  input  6  target frame index.
REQ-011 cmd_data  input  FrameBitsPerRow  frame data word.
REQ-012 cmd_last  input  1  marks final command of session.
REQ-013 FrameData  output  FrameBitsPerRow  registered data driven to the tile column.
REQ-014 FrameStrobe  output  MaxFramesPerCol  registered one-hot strobe to the column.
REQ-015 OutputEnable  output  1  registered fabric output enable; low while configuring.
REQ-016 busy  output  1  high while a session is open.
REQ-017 err  output  1  sticky flag: out-of-range frame index received this session.

Function
REQ-018 States SHALL be IDLE, OPEN, SETUP, STROBE, HOLD, CLOSE.
REQ-019 IDLE: cmd_ready=0; cfg_start=1 -> OPEN, busy<=1, OutputEnable<=0, err<=0 at same edge.
REQ-020 cfg_start SHALL be ignored in every state except IDLE.
REQ-021 cmd_ready SHALL be 1 exactly when state is OPEN (combinational from state).
REQ-022 OPEN, accept with cmd_frame < MaxFramesPerCol: FrameData<=cmd_data, frame index and cmd_last latched, -> SETUP.
REQ-023 OPEN, accept with cmd_frame >= MaxFramesPerCol: err<=1, FrameData and FrameStrobe unchanged, command dropped; -> CLOSE if cmd_last else stay OPEN.
REQ-024 SETUP SHALL last SetupCycles cycles with FrameStrobe=0, then -> STROBE.
REQ-025 STROBE SHALL last StrobeCycles cycles with FrameStrobe = one-hot bit of latched index, all other bits 0.
REQ-026 HOLD SHALL last 1 cycle with FrameStrobe=0 and FrameData unchanged; then -> CLOSE if latched last else OPEN.
REQ-027 CLOSE SHALL last 1 cycle; on exit OutputEnable<=1, busy<=0, -> IDLE.
REQ-028 FrameData SHALL change only on a valid accept or reset; it holds last value in IDLE.
REQ-029 At most one FrameStrobe bit SHALL be high in any cycle; never high outside STROBE.
REQ-030 Per-frame throughput (defaults): accept at edge T -> FrameData valid from T+1, strobe high T+2..T+3, HOLD T+4, cmd_ready high again T+5.
REQ-031 Internal cycle counter SHALL be 3 bits, reloaded on each SETUP/STROBE entry; no wrap beyond parameter value.
REQ-032 cmd_valid with cmd_ready=0 SHALL have no effect; inputs need not stay stable.

Reset
REQ-033 Reset=1 at an edge SHALL force: state IDLE, FrameData=0, FrameStrobe=0, OutputEnable=1, busy=0, err=0, cmd_ready=0.
REQ-034 Reset SHALL take priority over all inputs, including mid-STROBE: strobe cleared at that edge, no further pulse after release.
REQ-035 After Reset release the block SHALL require a new cfg_start before accepting commands.

Verification
REQ-036 Single frame: cfg_start, then cmd frame=5 data=0xA5A5_0F0F last=1 -> FrameData=0xA5A5_0F0F, FrameStrobe=0x0_0000_0020 for 2 cycles, OutputEnable low from cfg_start+1 until CLOSE exit, busy then 0.
REQ-037 Full column: frames 0..35 back-to-back with cmd_valid held high -> each strobe bit pulses once in order, 5 cycles per frame, never two bits high.
REQ-038 Out-of-range: frame=36 then frame=2 last=1 -> err=1, no strobe for 36, bit 2 strobed, err held until next cfg_start.
REQ-039 Reset mid-strobe: assert Reset in first STROBE cycle -> FrameStrobe=0, OutputEnable=1, FrameData=0 next cycle; later cmd_valid ignored until cfg_start.
REQ-040 cfg_start during OPEN and STROBE -> no state change, err not cleared; cmd_valid during SETUP/STROBE/HOLD -> not accepted.
REQ-041 Parameter sweep SetupCycles=3, StrobeCycles=1 -> strobe begins 4 cycles after accept, lasts 1 cycle.

Source files
------------

// File: rtl/frame_strobe_sequencer_if.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer_if
// Bundles the session/command handshake and the tile-column outputs of
// frame_strobe_sequencer.
//   master : the configuration source (drives cfg_start and cmd_*, observes
//            cmd_ready and the column outputs)
//   slave  : the sequencer itself
// Signals:
//   cfg_start    single-cycle request to open a configuration session
//   cmd_valid    frame-write command valid
//   cmd_ready    command accepted on cmd_valid & cmd_ready at a rising edge
//   cmd_frame    target frame index (6 bits)
//   cmd_data     frame data word
//   cmd_last     final command of the session
//   FrameData    registered data word driven to the column
//   FrameStrobe  registered one-hot frame strobe
//   OutputEnable registered fabric output enable, low while configuring
//   busy         high while a session is open
//   err          sticky out-of-range flag for the current session
// ---------------------------------------------------------------------------
interface frame_strobe_sequencer_if #(
  parameter int MaxFramesPerCol = 36,
  parameter int FrameBitsPerRow = 32
);
  logic                       cfg_start;
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [5:0]                 cmd_frame;
  logic [FrameBitsPerRow-1:0] cmd_data;
  logic                       cmd_last;
  logic [FrameBitsPerRow-1:0] FrameData;
  logic [MaxFramesPerCol-1:0] FrameStrobe;
  logic                       OutputEnable;
  logic                       busy;
  logic                       err;

  modport master (
    output cfg_start, cmd_valid, cmd_frame, cmd_data, cmd_last,
    input  cmd_ready, FrameData, FrameStrobe, OutputEnable, busy, err
  );

  modport slave (
    input  cfg_start, cmd_valid, cmd_frame, cmd_data, cmd_last,
    output cmd_ready, FrameData, FrameStrobe, OutputEnable, busy, err
  );
endinterface

// File: rtl/frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// frame_strobe_sequencer
// Writes configuration frames into a tile column. A session is opened with
// cfg_start; each accepted command places its data word on FrameData, waits
// SetupCycles with no strobe, pulses the one-hot FrameStrobe bit of the frame
// for StrobeCycles, then holds one cycle before accepting the next command.
// OutputEnable is low for the whole session; err flags any out-of-range
// frame index received during the session.
// Ports:
//   UserCLK  sole clock, all state on its rising edge
//   Reset    synchronous active-high reset
//   bus      frame_strobe_sequencer_if slave modport (handshake + column)
// ---------------------------------------------------------------------------
module frame_strobe_sequencer #(
  parameter int MaxFramesPerCol = 36,
  parameter int FrameBitsPerRow = 32,
  parameter int SetupCycles     = 1,
  parameter int StrobeCycles    = 2
) (
  input  logic                      UserCLK,
  input  logic                      Reset,
  frame_strobe_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPEN   = 3'd1,
    SETUP  = 3'd2,
    STROBE = 3'd3,
    HOLD   = 3'd4,
    CLOSE  = 3'd5
  } state_e;

  // The counter is loaded with (cycles - 1) on entry and the state is left
  // when it reaches zero, so it never wraps past the parameter value.
  localparam logic [2:0] SetupReload  = 3'(SetupCycles - 1);
  localparam logic [2:0] StrobeReload = 3'(StrobeCycles - 1);

  state_e                     state_q, state_d;
  logic [2:0]                 cnt_q, cnt_d;
  logic [5:0]                 idx_q, idx_d;
  logic                       last_q, last_d;
  logic [FrameBitsPerRow-1:0] data_q, data_d;
  logic [MaxFramesPerCol-1:0] strobe_q, strobe_d;
  logic                       oe_q, oe_d;
  logic                       busy_q, busy_d;
  logic                       err_q, err_d;
  logic                       in_range;

  assign in_range = 32'(bus.cmd_frame) < 32'(MaxFramesPerCol);

  // Next-state and next-value logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    data_d  = data_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start) begin
          state_d = OPEN;
          busy_d  = 1'b1;
          oe_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      OPEN: begin
        if (bus.cmd_valid) begin
          if (in_range) begin
            data_d  = bus.cmd_data;
            idx_d   = bus.cmd_frame;
            last_d  = bus.cmd_last;
            cnt_d   = SetupReload;
            state_d = SETUP;
          end else begin
            // Bad index: flag it and drop the command, column untouched.
            err_d = 1'b1;
            if (bus.cmd_last) state_d = CLOSE;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 3'd0) begin
          cnt_d   = StrobeReload;
          state_d = STROBE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 3'd0) state_d = HOLD;
        else               cnt_d   = cnt_q - 3'd1;
      end
      HOLD: begin
        state_d = last_q ? CLOSE : OPEN;
      end
      CLOSE: begin
        state_d = IDLE;
        oe_d    = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe is registered from the next state so it is high exactly while
  // the sequencer sits in STROBE; only the latched index can be set.
  always_comb begin
    strobe_d = '0;
    if (state_d == STROBE) begin
      for (int i = 0; i < MaxFramesPerCol; i++) begin
        strobe_d[i] = (idx_q == 6'(i));
      end
    end
  end

  always_ff @(posedge UserCLK) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      data_q   <= '0;
      strobe_q <= '0;
      oe_q     <= 1'b1;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
      oe_q     <= oe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Latched command fields are only read after being written by an accept.
  always_ff @(posedge UserCLK) begin
    idx_q  <= idx_d;
    last_q <= last_d;
  end

  assign bus.cmd_ready    = (state_q == OPEN);
  assign bus.FrameData    = data_q;
  assign bus.FrameStrobe  = strobe_q;
  assign bus.OutputEnable = oe_q;
  assign bus.busy         = busy_q;
  assign bus.err          = err_q;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_strobe_sequencer
// Two sequencers (default timing, and SetupCycles=3/StrobeCycles=1) share one
// stimulus stream. A timeline model per instance predicts, from each accept
// edge, the cycles in which the strobe, ready, and session close must occur.
// ---------------------------------------------------------------------------
module tb_frame_strobe_sequencer;
  localparam int NF = 36;
  localparam int W  = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          cfg_start, cmd_valid, cmd_last;
  logic [5:0]    cmd_frame;
  logic [W-1:0]  cmd_data;

  frame_strobe_sequencer_if #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W)) if0 ();
  frame_strobe_sequencer_if #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W)) if1 ();

  assign if0.cfg_start = cfg_start;
  assign if0.cmd_valid = cmd_valid;
  assign if0.cmd_frame = cmd_frame;
  assign if0.cmd_data  = cmd_data;
  assign if0.cmd_last  = cmd_last;
  assign if1.cfg_start = cfg_start;
  assign if1.cmd_valid = cmd_valid;
  assign if1.cmd_frame = cmd_frame;
  assign if1.cmd_data  = cmd_data;
  assign if1.cmd_last  = cmd_last;

  frame_strobe_sequencer #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W),
                           .SetupCycles(1), .StrobeCycles(2))
    dut0 (.UserCLK(clk), .Reset(rst), .bus(if0.slave));
  frame_strobe_sequencer #(.MaxFramesPerCol(NF), .FrameBitsPerRow(W),
                           .SetupCycles(3), .StrobeCycles(1))
    dut1 (.UserCLK(clk), .Reset(rst), .bus(if1.slave));

  logic          o_ready [2];
  logic [W-1:0]  o_data  [2];
  logic [NF-1:0] o_strb  [2];
  logic          o_oe    [2];
  logic          o_busy  [2];
  logic          o_err   [2];
  assign o_ready[0] = if0.cmd_ready;    assign o_ready[1] = if1.cmd_ready;
  assign o_data[0]  = if0.FrameData;    assign o_data[1]  = if1.FrameData;
  assign o_strb[0]  = if0.FrameStrobe;  assign o_strb[1]  = if1.FrameStrobe;
  assign o_oe[0]    = if0.OutputEnable; assign o_oe[1]    = if1.OutputEnable;
  assign o_busy[0]  = if0.busy;         assign o_busy[1]  = if1.busy;
  assign o_err[0]   = if0.err;          assign o_err[1]   = if1.err;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int setup_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic int strobe_of(int k);
    return (k == 0) ? 2 : 1;
  endfunction

  // Timeline model: edges counts rising edges; "after edge e" is the cycle
  // observed at the following falling edge.
  int         edges = 0;
  bit         m_busy [2], m_oe [2], m_err [2], m_open [2];
  logic [W-1:0] m_data [2];
  int         m_ready_from [2], m_slo [2], m_shi [2], m_sframe [2], m_close_at [2];
  bit         rdy_prev;

  always @(posedge clk) begin
    edges = edges + 1;
    for (int k = 0; k < 2; k++) begin
      rdy_prev = m_open[k] && ((edges - 1) >= m_ready_from[k]);
      if (rst) begin
        m_busy[k] = 0; m_oe[k] = 1; m_err[k] = 0; m_open[k] = 0;
        m_data[k] = '0; m_slo[k] = 0; m_shi[k] = -1; m_close_at[k] = -1;
        m_ready_from[k] = 0; m_sframe[k] = 0;
      end else if (m_close_at[k] == edges - 1) begin
        m_busy[k] = 0; m_oe[k] = 1; m_open[k] = 0; m_close_at[k] = -1;
      end else if (!m_busy[k]) begin
        if (cfg_start) begin
          m_busy[k] = 1; m_oe[k] = 0; m_err[k] = 0; m_open[k] = 1;
          m_ready_from[k] = edges;
        end
      end else if (rdy_prev && cmd_valid) begin
        if (int'(cmd_frame) < NF) begin
          m_data[k]   = cmd_data;
          m_sframe[k] = int'(cmd_frame);
          m_slo[k]    = edges + setup_of(k);
          m_shi[k]    = edges + setup_of(k) + strobe_of(k) - 1;
          if (cmd_last) begin
            m_open[k] = 0;
            m_close_at[k] = edges + setup_of(k) + strobe_of(k) + 1;
          end else begin
            m_ready_from[k] = edges + setup_of(k) + strobe_of(k) + 1;
          end
        end else begin
          m_err[k] = 1;
          if (cmd_last) begin
            m_open[k] = 0;
            m_close_at[k] = edges;
          end
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  logic [NF-1:0] exp_strb;
  bit            col_mode = 0;
  int            col_pulses, col_prev_edge, col_bit;
  logic [NF-1:0] prev_strb0 = '0;

  always @(negedge clk) begin
    if (edges > 0) begin
      for (int k = 0; k < 2; k++) begin
        exp_strb = '0;
        if (edges >= m_slo[k] && edges <= m_shi[k]) exp_strb[m_sframe[k]] = 1'b1;
        chk($sformatf("d%0d.ready@%0d", k, edges), 64'(o_ready[k]),
            64'(m_open[k] && edges >= m_ready_from[k]));
        chk($sformatf("d%0d.strobe@%0d", k, edges), 64'(o_strb[k]), 64'(exp_strb));
        chk($sformatf("d%0d.data@%0d", k, edges), 64'(o_data[k]), 64'(m_data[k]));
        chk($sformatf("d%0d.oe@%0d", k, edges), 64'(o_oe[k]), 64'(m_oe[k]));
        chk($sformatf("d%0d.busy@%0d", k, edges), 64'(o_busy[k]), 64'(m_busy[k]));
        chk($sformatf("d%0d.err@%0d", k, edges), 64'(o_err[k]), 64'(m_err[k]));
        chk($sformatf("d%0d.onehot@%0d", k, edges), 64'($countones(o_strb[k]) <= 1), 64'd1);
      end
      if (col_mode && ((o_strb[0] & ~prev_strb0) != '0)) begin
        for (int i = 0; i < NF; i++) if (o_strb[0][i] && !prev_strb0[i]) col_bit = i;
        chk("col_order", 64'(col_bit), 64'(col_pulses));
        if (col_pulses > 0) chk("col_spacing", 64'(edges - col_prev_edge), 64'd5);
        col_prev_edge = edges;
        col_pulses++;
      end
      prev_strb0 = o_strb[0];
    end
  end

  task automatic idle_inputs();
    cfg_start = 0; cmd_valid = 0; cmd_last = 0; cmd_frame = '0; cmd_data = '0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic start_session();
    cfg_start = 1;
    @(negedge clk);
    cfg_start = 0;
  endtask

  task automatic send_one(input logic [5:0] f, input logic [W-1:0] d, input logic l);
    cmd_valid = 1; cmd_frame = f; cmd_data = d; cmd_last = l;
    @(negedge clk);
    cmd_valid = 0;
  endtask

  initial begin
    int fr;
    rst = 1;
    idle_inputs();
    cycles(3);
    chk("reset_oe", 64'(o_oe[0]), 64'd1);
    chk("reset_ready", 64'(o_ready[0]), 64'd0);
    rst = 0;
    cycles(2);

    // Commands before any session must be ignored.
    cmd_valid = 1; cmd_frame = 6'd4; cmd_data = 32'hDEAD_BEEF;
    cycles(3);
    idle_inputs();

    // Single frame, checked explicitly against the published timeline.
    start_session();
    chk("single_oe_low", 64'(o_oe[0]), 64'd0);
    chk("single_busy", 64'(o_busy[0]), 64'd1);
    send_one(6'd5, 32'hA5A5_0F0F, 1'b1);
    chk("single_data", 64'(o_data[0]), 64'hA5A5_0F0F);
    chk("single_setup", 64'(o_strb[0]), 64'd0);
    cycles(1);
    chk("single_strobe1", 64'(o_strb[0]), 64'h20);
    cycles(1);
    chk("single_strobe2", 64'(o_strb[0]), 64'h20);
    chk("sweep_setup", 64'(o_strb[1]), 64'd0);
    cycles(1);
    chk("single_hold", 64'(o_strb[0]), 64'd0);
    chk("sweep_strobe", 64'(o_strb[1]), 64'h20);
    cycles(1);
    chk("sweep_strobe_end", 64'(o_strb[1]), 64'd0);
    cycles(1);
    chk("single_oe_back", 64'(o_oe[0]), 64'd1);
    chk("single_busy_done", 64'(o_busy[0]), 64'd0);
    cycles(4);

    // Out-of-range frame followed by a valid last frame.
    start_session();
    send_one(6'd36, 32'h1111_1111, 1'b0);
    chk("oor_err", 64'(o_err[0]), 64'd1);
    chk("oor_still_open", 64'(o_ready[0]), 64'd1);
    send_one(6'd2, 32'h2222_2222, 1'b1);
    cycles(10);
    chk("oor_err_held", 64'(o_err[0]), 64'd1);
    start_session();
    chk("oor_err_cleared", 64'(o_err[0]), 64'd0);

    // cfg_start while OPEN / STROBE, and commands held through SETUP..HOLD.
    send_one(6'd40, 32'h0, 1'b0);
    start_session();
    chk("restart_keeps_err", 64'(o_err[0]), 64'd1);
    cmd_valid = 1; cmd_frame = 6'd7; cmd_data = 32'h7777_0007; cmd_last = 0;
    @(negedge clk);
    cmd_frame = 6'd9; cmd_data = 32'h9999_0009; cmd_last = 1;
    cfg_start = 1;
    cycles(2);
    cfg_start = 0;
    cycles(3);
    cmd_valid = 0;
    cycles(12);

    // Reset in the first strobe cycle.
    start_session();
    send_one(6'd3, 32'h3333_3333, 1'b0);
    for (int c = 0; c < 20 && o_strb[0] == '0; c++) @(negedge clk);
    chk("rst_wait_strobe", 64'(o_strb[0]), 64'h8);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_strobe", 64'(o_strb[0]), 64'd0);
    chk("rst_oe", 64'(o_oe[0]), 64'd1);
    chk("rst_data", 64'(o_data[0]), 64'd0);
    cmd_valid = 1; cmd_frame = 6'd1;
    cycles(6);
    idle_inputs();
    cycles(2);

    // Full column with cmd_valid held high, frames 0..35 in order on dut0.
    col_mode = 1; col_pulses = 0; col_prev_edge = 0;
    cmd_valid = 1; cmd_frame = 6'd0; cmd_last = 0;
    start_session();
    fr = 0;
    for (int c = 0; c < 400 && fr < NF; c++) begin
      if (o_ready[0]) begin
        cmd_frame = 6'(fr); cmd_last = (fr == NF - 1); cmd_data = $urandom; fr++;
      end
      if (fr < NF) @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 0;
    chk("col_all_sent", 64'(fr), 64'(NF));
    cycles(30);
    col_mode = 0;
    chk("col_pulses", 64'(col_pulses), 64'(NF));
    idle_inputs();
    cycles(4);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 299) == 0);
      cfg_start = ($urandom_range(0, 15) == 0);
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_frame = 6'($urandom_range(0, 39));
      cmd_last  = ($urandom_range(0, 5) == 0);
      cmd_data  = $urandom;
      @(negedge clk);
    end
    rst = 0;
    idle_inputs();
    cycles(20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
